// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    // Two's-complement magnitude; INT_MIN maps to 2^31 read as unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply on {hi,lo}, or restoring divide with hi as remainder.
// Zero latency; no flow control.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = sum[XLEN:1];
        lo_next = {sum[0], lo[XLEN-1:1]};
        // Remainder stays below the divisor, so diff[XLEN] is exactly the borrow.
        if (is_div) begin
            if (diff[XLEN]) begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end else begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: Done 33 edges after the accepting edge (1 edge for special cases with MULDIV_FAST_SPECIAL_EN).
// No backpressure: start is taken only in IDLE and is dropped, not queued, while Busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      MDOp,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count;
    md_op_e            op_q, in_op;
    logic [XLEN-1:0]   opnd_q, hi_q, lo_q, a_raw_q, result_q;
    logic [XLEN-1:0]   hi_step, lo_step, fix_res, a_mag, b_mag;
    logic [2*XLEN-1:0] prod;
    logic              neg_q, div0_q, ovf_q;
    logic              a_neg, b_neg, in_div, in_div0, in_ovf, skip, accept;

    always_comb begin
        in_op   = md_op_e'(MDOp);
        in_div  = MDOp[2];
        a_neg   = A[XLEN-1] && (in_op == MD_MULH || in_op == MD_MULHSU || in_op == MD_DIV || in_op == MD_REM);
        b_neg   = B[XLEN-1] && (in_op == MD_MULH || in_op == MD_DIV || in_op == MD_REM);
        a_mag   = mag(A, a_neg);
        b_mag   = mag(B, b_neg);
        in_div0 = (B == '0);
        in_ovf  = (A == INT_MIN) && (B == '1) && (in_op == MD_DIV || in_op == MD_REM);
`ifdef MULDIV_FAST_SPECIAL_EN
        skip    = in_div ? (in_div0 || in_ovf) : (A == '0 || B == '0);
`else
        skip    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                accept  = 1'b1;
                state_d = skip ? ST_FIX : ST_CALC;
            end
            ST_CALC: if (count == LAST) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    muldiv_step u_step (
        .is_div  (op_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opnd_q),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q     <= MD_MUL;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            a_raw_q  <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            count    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                opnd_q  <= in_div ? b_mag : a_mag;
                hi_q    <= '0;
                lo_q    <= in_div ? a_mag : b_mag;
                a_raw_q <= A;
                neg_q   <= (in_op == MD_REM || in_op == MD_REMU) ? a_neg : (a_neg ^ b_neg);
                div0_q  <= in_div0;
                ovf_q   <= in_ovf;
            end else if (state_q == ST_CALC) begin
                hi_q  <= hi_step;
                lo_q  <= lo_step;
                count <= (count == LAST) ? '0 : count + CNT_W'(1);
            end
            if (state_q == ST_FIX) result_q <= fix_res;
        end
    end

`ifdef MULDIV_FAST_SPECIAL_EN
    logic mul_zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n)      mul_zero_q <= 1'b0;
        else if (accept) mul_zero_q <= !in_div && (A == '0 || B == '0);
    end
`endif

    always_comb begin
        prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        case (op_q)
            MD_MUL:                       fix_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = div0_q ? DIV0_QUOT : (ovf_q ? INT_MIN : (neg_q ? -lo_q : lo_q));
            default:                      fix_res = div0_q ? a_raw_q : (ovf_q ? '0 : (neg_q ? -hi_q : hi_q));
        endcase
`ifdef MULDIV_FAST_SPECIAL_EN
        if (mul_zero_q) fix_res = '0;
`endif
    end

    assign Busy   = (state_q != ST_IDLE);
    assign Done   = (state_q == ST_DONE);
    assign Result = result_q;
    assign Zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, Busy/hold behaviour, ignored start and mid-op reset.
module tb_muldiv_unit;

    localparam int FULL_LAT = 33;
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A, B;
    logic [2:0]  MDOp;
    logic        Busy, Done, Zero;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .MDOp   (MDOp),
        .Busy   (Busy),
        .Done   (Done),
        .Result (Result),
        .Zero   (Zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after Done.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic        busy_ok, hold_ok;
        logic [31:0] prev;
        prev  = Result;
        MDOp  = op;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        MDOp  = ~op;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        while (!Done && lat < 200) begin
            busy_ok &= Busy;
            hold_ok &= (Result === prev);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, {31'd0, busy_ok & Busy}, 32'd1);
        chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({tag, "_res"}, Result, exp_res);
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp_res == 32'd0});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'd0, Done, Busy}, 32'd0);
    endtask

    initial begin
        int saw_done;
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        MDOp  = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {29'd0, Busy, Done, Zero}, 32'd1);
        chk("reset_result", Result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Each op starts in the cycle right after the previous Done.
        do_op("mul",    3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, FULL_LAT);
        do_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, FULL_LAT);
        do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
        do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, FULL_LAT);
        do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, FULL_LAT);
        do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, FULL_LAT);
        do_op("divu",   3'b101, 32'd100,       32'd7,         32'd14,        FULL_LAT);
        do_op("remu",   3'b111, 32'd100,       32'd7,         32'd2,         FULL_LAT);
        do_op("divu0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT);
        do_op("remu0",  3'b111, 32'd5,         32'd0,         32'd5,         SPEC_LAT);
        do_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        do_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_LAT);
        do_op("div_s0", 3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SPEC_LAT);
        do_op("rem_s0", 3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPEC_LAT);
        do_op("mul_nz", 3'b000, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, FULL_LAT);
        do_op("mulhsu_neg", 3'b010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, FULL_LAT);
        do_op("mulh_neg", 3'b001, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, FULL_LAT);

        // A second start during a DIV is dropped, and nothing is queued behind it.
        fork
            do_op("div_ign", 3'b101, 32'd100, 32'd7, 32'd14, FULL_LAT);
            begin
                repeat (10) @(negedge clk);
                start = 1'b1;
                MDOp  = 3'b101;
                @(negedge clk);
                start = 1'b0;
            end
        join
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) saw_done++;
        end
        chk("ign_no_second_done", 32'(saw_done), 32'd0);
        chk("ign_result_kept", Result, 32'd14);

        // Reset at cycle 20 of a MUL discards it.
        MDOp  = 3'b000;
        A     = 32'd9;
        B     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_flags", {30'd0, Busy, Done}, 32'd0);
        chk("midrst_result", Result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 3'b000, 32'd6, 32'd7, 32'd42, FULL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
